// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle adder/subtractor. Two WIDTH-bit operands are added CHUNK bits
//   per clock. A carry register passes the carry from one chunk to the next,
//   so the combinational carry chain is only CHUNK bits long.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request. It is sampled only while busy is low.
//   sub        0: a + b + cin, 1: a - b (two's complement)
//   a, b       operands. They are captured at the edge that accepts start.
//   cin        carry-in for add. It is ignored when sub is high.
//   sum        result. It is held from done until the next accepted start.
//   cout       carry out of the MSB. In sub mode, 1 means no borrow.
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   busy       high during the N compute cycles
//   done       one-cycle pulse in the cycle after the last chunk is written
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: start is accepted on any rising edge where start=1 and busy=0.
// The done cycle counts as busy=0, so a start in that cycle gives
// back-to-back operation. A start seen while busy=1 is dropped.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic             dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;    // already inverted for subtract
  logic             carry;
  logic [KW-1:0]    k;

  int               lsb;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             c_ch;
  logic             msb_cin;
  logic             last;

  // Datapath for the chunk selected by k.
  always_comb begin
    lsb          = 32'(k) * CHUNK;
    a_ch         = a_r[lsb +: CHUNK];
    b_ch         = b_r[lsb +: CHUNK];
    {c_ch, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK + 1)'(carry);
    // Recover the carry into the top bit of this chunk from the sum bit:
    // s = a ^ b ^ cin_bit. This works for any CHUNK, including 1.
    msb_cin      = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];
    last         = (k == KW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[lsb +: CHUNK] <= s_ch;
          carry             <= c_ch;
          k                 <= k + 1'b1;
          if (last) begin
            cout  <= c_ch;
            ovf   <= c_ch ^ msb_cin;
            busy  <= 1'b0;
            done  <= 1'b1;
            k     <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = (state == RUN);

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks through a carry register.
- Next generation of the team's 4-bit ripple adder. Adds configurable width, subtract mode, carry-in, signed overflow and a start/busy/done handshake.
- Trades latency for a short CHUNK-bit carry chain. Used in datapaths where the full-width combinational ripple does not meet timing.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle. 1 <= CHUNK <= WIDTH.
- Derived: N = WIDTH/CHUNK, the number of compute cycles.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = a+b+cin, 1 = a-b (two's complement).
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in for add; ignored when sub=1.
- sum  output  WIDTH  result; held from done until the next accepted start.
- cout  output  1  carry out of the MSB. In sub mode 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset: rst=1 at a clock edge forces state=IDLE. sum=0, cout=0, ovf=0, busy=0, done=0. Operand and carry registers are cleared.
  - Reset wins over every other input, including mid-operation; a partial result is discarded.
- FSM states: IDLE, RUN. done is a registered pulse, not a separate state.
- IDLE, start=1 at edge E0:
  - Capture A=a.
  - Capture B = sub ? ~b : b.
  - Set carry = sub ? 1 : cin.
  - Set chunk index k=0, busy=1, done=0.
  - sum, cout and ovf keep their old values until the first chunk is written.
- RUN, edge E(k+1), for k = 0..N-1:
  - Compute {c, s} = A[k*CHUNK +: CHUNK] + B[k*CHUNK +: CHUNK] + carry.
  - Write sum[k*CHUNK +: CHUNK] = s. Set carry = c.
  - On the last chunk (k = N-1):
    - cout = c.
    - ovf = c XOR (carry into bit WIDTH-1), computed inside the final chunk.
    - busy=0, done=1, state -> IDLE.
- Latency: start sampled at E0 gives done=1 in the cycle after edge EN. busy is high for exactly N cycles.
- done is high for exactly one cycle. sum, cout and ovf stay stable until the next accepted start.
- start while busy=1 is ignored: no restart and no operand recapture.
- start in the done cycle is accepted, since busy=0 then. done drops at the next edge, giving back-to-back operation with throughput of one result per N+1 cycles.
- a, b, cin and sub only matter at the accepting edge; later changes have no effect.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - No sign extension.
  - Result sum is bit-exact with combinational (a + b + cin) or (a - b) at WIDTH bits.
- CHUNK=WIDTH (N=1): single compute cycle; busy high for one cycle.
- CHUNK=1: bit-serial; N=WIDTH.

Test Plan (WIDTH=16, CHUNK=4, N=4 unless stated):
1. Assert rst for 2 cycles -> sum=0x0000, cout=0, ovf=0, busy=0, done=0. start held during rst has no effect.
2. Add a=0x0001, b=0x0006, cin=0 -> busy high 4 cycles; done pulse in 5th cycle; sum=0x0007, cout=0, ovf=0.
3. Add a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
4. Sub cases:
   - a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0.
   - a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
5. Protocol cases:
   - Start 0x1000+0x0234; pulse start with different operands during busy; change a/b mid-run -> sum=0x1234, done still exactly 4 cycles after the original start.
   - Start asserted in the done cycle -> accepted; next done occurs 4 cycles later.
6. Reset and parameter sweep:
   - Assert rst in the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0. The following start with 0x00FF+0x0001 gives 0x0100.
   - Repeat tests 2-4 with CHUNK=1 (N=16) and CHUNK=16 (N=1), plus 200 random vectors against a reference model.
